// File: rtl/issue_scoreboard_if.sv
// Decode/execute-side handshake bundle for issue_scoreboard.
// master: decode drives issue_* and flush; slave: scoreboard drives grant, wb, status.
interface issue_scoreboard_if #(
   parameter int ADDR_W  = 5,
   parameter int MAX_LAT = 8,
   parameter int CNT_W   = 32
);
   localparam int LAT_W = $clog2(MAX_LAT + 1);

   logic              flush;
   logic              issue_valid;
   logic [ADDR_W-1:0] issue_rs1;
   logic              issue_rs1_used;
   logic [ADDR_W-1:0] issue_rs2;
   logic              issue_rs2_used;
   logic [ADDR_W-1:0] issue_rd;
   logic              issue_rd_we;
   logic [LAT_W-1:0]  issue_lat;
   logic              issue_ready;
   logic              wb_valid;
   logic [ADDR_W-1:0] wb_rd;
   logic              busy;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output flush, issue_valid, issue_rs1, issue_rs1_used,
      output issue_rs2, issue_rs2_used, issue_rd, issue_rd_we,
      output issue_lat,
      input  issue_ready, wb_valid, wb_rd, busy, stall_cnt
   );

   modport slave (
      input  flush, issue_valid, issue_rs1, issue_rs1_used,
      input  issue_rs2, issue_rs2_used, issue_rd, issue_rd_we,
      input  issue_lat,
      output issue_ready, wb_valid, wb_rd, busy, stall_cnt
   );
endinterface

// File: rtl/issue_scoreboard.sv
// Register scoreboard + writeback-slot reservation: grants issue when free of
// RAW/WAW hazards and write-port collisions; drives wb_valid/wb_rd.
// Ports: clk, rst (sync, active-high), sb (issue_scoreboard_if.slave).
// Optional: define SCOREBOARD_FWD_EN to let slot-0 completions bypass hazards.
module issue_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int MAX_LAT  = 8,
   parameter int CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   issue_scoreboard_if.slave sb
);
   localparam int LAT_W = $clog2(MAX_LAT + 1);

   logic [NUM_REGS-1:0] pending;
   logic [MAX_LAT-1:0]  slot_v;
   logic [ADDR_W-1:0]   slot_rd [MAX_LAT];
   logic [CNT_W-1:0]    stall_q;

   logic [NUM_REGS-1:0] blk;
   logic                writes;
   logic                hit;
   logic                coll;
   logic                lat_ok;
   logic                ready;
   logic                gnt_wr;

   assign writes = sb.issue_rd_we && (sb.issue_rd != '0);

   // Pending bits that actually block issue.
   always_comb begin
      blk = pending;
`ifdef SCOREBOARD_FWD_EN
      // Only outstanding write completes now: bypass supplies the data.
      for (int j = 1; j < NUM_REGS; j++) begin
         if (slot_v[0] && slot_rd[0] == ADDR_W'(j)) begin
            blk[j] = 1'b0;
            for (int k = 1; k < MAX_LAT; k++)
               if (slot_v[k] && slot_rd[k] == ADDR_W'(j))
                  blk[j] = 1'b1;
         end
      end
`endif
   end

   always_comb begin
      hit  = 1'b0;
      coll = 1'b0;
      for (int j = 1; j < NUM_REGS; j++) begin
         if (blk[j]) begin
            if (sb.issue_rs1_used && sb.issue_rs1 == ADDR_W'(j))
               hit = 1'b1;
            if (sb.issue_rs2_used && sb.issue_rs2 == ADDR_W'(j))
               hit = 1'b1;
            if (writes && sb.issue_rd == ADDR_W'(j))
               hit = 1'b1;
         end
      end
      // Landing slot L-1 is taken next edge by whatever sits in slot L now.
      for (int k = 1; k < MAX_LAT; k++)
         if (writes && slot_v[k] && sb.issue_lat == LAT_W'(k))
            coll = 1'b1;
   end

   assign lat_ok = (sb.issue_lat != '0) &&
                   (sb.issue_lat <= LAT_W'(MAX_LAT));
   assign ready  = lat_ok && !hit && !coll;
   assign gnt_wr = sb.issue_valid && ready && writes;

   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
         slot_v  <= '0;
         stall_q <= '0;
         for (int k = 0; k < MAX_LAT; k++)
            slot_rd[k] <= '0;
      end else begin
         if (sb.issue_valid && !ready)
            stall_q <= stall_q + CNT_W'(1);
         if (sb.flush) begin
            pending <= '0;
            slot_v  <= '0;
         end else begin
            for (int k = 0; k < MAX_LAT - 1; k++) begin
               slot_v[k]  <= slot_v[k+1];
               slot_rd[k] <= slot_rd[k+1];
            end
            slot_v[MAX_LAT-1]  <= 1'b0;
            slot_rd[MAX_LAT-1] <= '0;
            for (int k = 0; k < MAX_LAT; k++) begin
               if (gnt_wr && sb.issue_lat == LAT_W'(k + 1)) begin
                  slot_v[k]  <= 1'b1;
                  slot_rd[k] <= sb.issue_rd;
               end
            end
            // Clear first, set after: a same-edge grant keeps the bit.
            for (int j = 1; j < NUM_REGS; j++) begin
               if (slot_v[0] && slot_rd[0] == ADDR_W'(j))
                  pending[j] <= 1'b0;
               if (gnt_wr && sb.issue_rd == ADDR_W'(j))
                  pending[j] <= 1'b1;
            end
         end
      end
   end

   assign sb.issue_ready = ready;
   assign sb.wb_valid    = slot_v[0];
   assign sb.wb_rd       = slot_rd[0];
   assign sb.busy        = (|pending) || (|slot_v);
   assign sb.stall_cnt   = stall_q;
endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: writeback scoreboard queue,
// hazard/collision/flush scenarios and stall-counter wrap.
module tb_issue_scoreboard;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   issue_scoreboard_if #(.ADDR_W(5), .MAX_LAT(8), .CNT_W(32)) bus ();
   issue_scoreboard_if #(.ADDR_W(5), .MAX_LAT(8), .CNT_W(4))  bus2 ();

   issue_scoreboard #(.NUM_REGS(32), .ADDR_W(5), .MAX_LAT(8), .CNT_W(32))
      u_dut (.clk(clk), .rst(rst), .sb(bus));
   issue_scoreboard #(.NUM_REGS(32), .ADDR_W(5), .MAX_LAT(8), .CNT_W(4))
      u_small (.clk(clk), .rst(rst), .sb(bus2));

   typedef struct {
      int         cyc;
      logic [4:0] rd;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   stall_exp = 0;
   bit   mon_en = 1'b0;

`ifdef SCOREBOARD_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   always @(posedge clk) cyc <= cyc + 1;

   // Writeback monitor: every wb must match the queue head in cycle and rd.
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.wb_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL wb_spurious cyc=%0d rd=%0d expected none",
                        cyc, bus.wb_rd);
            end else if (q[0].cyc != cyc || q[0].rd !== bus.wb_rd) begin
               errors++;
               $display("FAIL wb_match cyc=%0d rd=%0d expected cyc=%0d rd=%0d",
                        cyc, bus.wb_rd, q[0].cyc, q[0].rd);
            end
            if (q.size() != 0 && q[0].cyc <= cyc) void'(q.pop_front());
         end else if (q.size() != 0 && q[0].cyc <= cyc) begin
            checks++;
            errors++;
            $display("FAIL wb_missing cyc=%0d wb_valid=%b expected rd=%0d",
                     cyc, bus.wb_valid, q[0].rd);
            void'(q.pop_front());
         end
      end
   end

   task automatic push_exp(input int c, input logic [4:0] rd);
      exp_t e;
      int   i;
      e.cyc = c;
      e.rd  = rd;
      i = 0;
      while (i < q.size() && q[i].cyc <= c) i++;
      q.insert(i, e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.flush          = 1'b0;
      bus.issue_valid    = 1'b0;
      bus.issue_rs1      = '0;
      bus.issue_rs1_used = 1'b0;
      bus.issue_rs2      = '0;
      bus.issue_rs2_used = 1'b0;
      bus.issue_rd       = '0;
      bus.issue_rd_we    = 1'b0;
      bus.issue_lat      = 4'd1;
      bus2.flush          = 1'b0;
      bus2.issue_valid    = 1'b0;
      bus2.issue_rs1      = '0;
      bus2.issue_rs1_used = 1'b0;
      bus2.issue_rs2      = '0;
      bus2.issue_rs2_used = 1'b0;
      bus2.issue_rd       = '0;
      bus2.issue_rd_we    = 1'b0;
      bus2.issue_lat      = 4'd1;
   endtask

   // Offer a writing instruction for one cycle.
   task automatic do_issue(input logic [4:0] rd, input logic [3:0] lat,
                           input logic exp_rdy, input string nm);
      bus.issue_valid    = 1'b1;
      bus.issue_rs1_used = 1'b0;
      bus.issue_rs2_used = 1'b0;
      bus.issue_rd       = rd;
      bus.issue_rd_we    = 1'b1;
      bus.issue_lat      = lat;
      #1;
      checks++;
      if (bus.issue_ready !== exp_rdy) begin
         errors++;
         $display("FAIL %s ready=%b expected %b", nm, bus.issue_ready, exp_rdy);
      end
      if (exp_rdy && rd != 5'd0) push_exp(cyc + int'(lat), rd);
      if (!exp_rdy) stall_exp++;
      step();
      idle();
   endtask

   // Hold a reader of r for n stalled cycles, then expect the grant.
   task automatic hold_raw(input logic [4:0] r, input int n, input string nm);
      bus.issue_valid    = 1'b1;
      bus.issue_rs1      = r;
      bus.issue_rs1_used = 1'b1;
      bus.issue_rd_we    = 1'b0;
      bus.issue_lat      = 4'd1;
      for (int i = 0; i < n; i++) begin
         #1;
         checks++;
         if (bus.issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_stall%0d ready=%b expected 0",
                     nm, i, bus.issue_ready);
         end
         step();
         stall_exp++;
      end
      #1;
      checks++;
      if (bus.issue_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_release ready=%b expected 1", nm, bus.issue_ready);
      end
      step();
      idle();
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      step();
      step();
      checks++;
      if (bus.wb_valid !== 1'b0 || bus.busy !== 1'b0 ||
          bus.stall_cnt !== 32'd0 || bus.issue_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset wb=%b busy=%b stall=%0d ready=%b expected 0 0 0 1",
                  bus.wb_valid, bus.busy, bus.stall_cnt, bus.issue_ready);
      end
      rst = 1'b0;
      mon_en = 1'b1;
   endtask

   task automatic test_raw();
      do_issue(5'd5, 4'd3, 1'b1, "raw_issue");
      hold_raw(5'd5, FWD ? 2 : 3, "raw");
      checks++;
      if (bus.stall_cnt !== 32'(stall_exp)) begin
         errors++;
         $display("FAIL raw_stall_cnt got=%0d expected %0d",
                  bus.stall_cnt, stall_exp);
      end
   endtask

   task automatic test_collision();
      do_issue(5'd4, 4'd4, 1'b1, "coll_first");
      bus.issue_valid = 1'b1;
      bus.issue_rd    = 5'd6;
      bus.issue_rd_we = 1'b1;
      bus.issue_lat   = 4'd3;
      #1;
      checks++;
      if (bus.issue_ready !== 1'b0) begin
         errors++;
         $display("FAIL coll_l3 ready=%b expected 0", bus.issue_ready);
      end
      bus.issue_lat = 4'd2;
      #1;
      checks++;
      if (bus.issue_ready !== 1'b1) begin
         errors++;
         $display("FAIL coll_l2 ready=%b expected 1", bus.issue_ready);
      end
      push_exp(cyc + 2, 5'd6);
      step();
      bus.issue_rd  = 5'd4;
      bus.issue_lat = 4'd1;
      #1;
      checks++;
      if (bus.issue_ready !== 1'b0) begin
         errors++;
         $display("FAIL coll_waw ready=%b expected 0", bus.issue_ready);
      end
      idle();
      repeat (4) step();
   endtask

   task automatic test_rd0_illegal();
      do_issue(5'd0, 4'd2, 1'b1, "rd0_grant");
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL rd0_busy busy=%b expected 0", bus.busy);
      end
      bus.issue_valid = 1'b1;
      bus.issue_lat   = 4'd0;
      #1;
      checks++;
      if (bus.issue_ready !== 1'b0) begin
         errors++;
         $display("FAIL lat0 ready=%b expected 0", bus.issue_ready);
      end
      bus.issue_lat = 4'd9;
      #1;
      checks++;
      if (bus.issue_ready !== 1'b0) begin
         errors++;
         $display("FAIL lat9 ready=%b expected 0", bus.issue_ready);
      end
      idle();
      repeat (3) step();
   endtask

   task automatic test_flush();
      do_issue(5'd1, 4'd8, 1'b1, "fl_r1");
      do_issue(5'd2, 4'd8, 1'b1, "fl_r2");
      do_issue(5'd3, 4'd8, 1'b1, "fl_r3");
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL fl_busy_before busy=%b expected 1", bus.busy);
      end
      bus.flush       = 1'b1;
      bus.issue_valid = 1'b1;
      bus.issue_rd    = 5'd7;
      bus.issue_rd_we = 1'b1;
      bus.issue_lat   = 4'd2;
      step();
      q.delete();
      idle();
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL fl_busy_after busy=%b expected 0", bus.busy);
      end
      bus.issue_valid    = 1'b1;
      bus.issue_rs1      = 5'd7;
      bus.issue_rs1_used = 1'b1;
      bus.issue_rs2      = 5'd1;
      bus.issue_rs2_used = 1'b1;
      #1;
      checks++;
      if (bus.issue_ready !== 1'b1) begin
         errors++;
         $display("FAIL fl_pending_clear ready=%b expected 1", bus.issue_ready);
      end
      idle();
      repeat (10) step();
      checks++;
      if (bus.stall_cnt !== 32'(stall_exp)) begin
         errors++;
         $display("FAIL fl_stall_cnt got=%0d expected %0d",
                  bus.stall_cnt, stall_exp);
      end
   endtask

   task automatic test_stall();
      do_issue(5'd9, 4'd8, 1'b1, "st_issue");
      hold_raw(5'd9, FWD ? 7 : 8, "st_a");
      do_issue(5'd10, 4'd3, 1'b1, "st_issue2");
      bus.issue_rs2 = 5'd10;
      hold_raw(5'd10, FWD ? 2 : 3, "st_b");
      checks++;
      if (bus.stall_cnt !== 32'(stall_exp)) begin
         errors++;
         $display("FAIL stall_cnt got=%0d expected %0d",
                  bus.stall_cnt, stall_exp);
      end
   endtask

   task automatic test_wrap();
      bus2.issue_valid = 1'b1;
      bus2.issue_lat   = 4'd0;
      repeat (17) step();
      bus2.issue_valid = 1'b0;
      bus2.issue_lat   = 4'd1;
      #1;
      checks++;
      if (bus2.stall_cnt !== 4'd1) begin
         errors++;
         $display("FAIL wrap stall_cnt got=%0d expected 1", bus2.stall_cnt);
      end
   endtask

   task automatic test_drain();
      repeat (10) step();
      checks++;
      if (q.size() != 0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL drain queue=%0d busy=%b expected 0 0",
                  q.size(), bus.busy);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_raw();
      test_collision();
      test_rd0_illegal();
      test_flush();
      test_stall();
      test_wrap();
      test_drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
